// File: rtl/imem_boot_loader_if.sv
// Byte-stream download link plus instruction-memory write port of the boot loader.
// master = loader side (consumes bytes, drives writes); slave = link source / memory side.
interface imem_boot_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] imem_waddress;
  logic [31:0] imem_wdata;
  logic        imem_wr;

  modport master (input byte_in, byte_valid, output byte_ready, imem_waddress, imem_wdata, imem_wr);
  modport slave  (output byte_in, byte_valid, input byte_ready, imem_waddress, imem_wdata, imem_wr);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: header N, N little-endian words written to imem, XOR checksum byte; core held until verified.
// Optional idle timeout enabled by defining IMEM_LOADER_TIMEOUT_EN.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               start,
  imem_boot_loader_if.master bus,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR} state_e;

  state_e      state_q;
  logic [1:0]  bcnt_q;
  logic [31:0] n_q, widx_q, word_q, addr_q, wdata_q;
  logic [7:0]  csum_q;
  logic        ready_q, wr_q, busy_q, done_q, error_q, hold_q;
  logic [1:0]  code_q;
  logic        xfer, tmo;
  logic [31:0] shift_n, shift_w;

  assign xfer    = bus.byte_valid & ready_q;
  assign shift_n = {bus.byte_in, n_q[31:8]};
  assign shift_w = {bus.byte_in, word_q[31:8]};

`ifdef IMEM_LOADER_TIMEOUT_EN
  logic [31:0] idle_q;
  logic        counting;
  assign counting = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign tmo      = counting && !xfer && (idle_q == TIMEOUT_CYCLES - 1);

  // Held at zero outside the waiting states, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (Reset || !counting || xfer) idle_q <= '0;
    else                            idle_q <= idle_q + 32'd1;
  end
`else
  assign tmo = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      n_q     <= '0;
      widx_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
      code_q  <= 2'b00;
    end else begin
      wr_q <= 1'b0;
      if (tmo) begin
        state_q <= S_ERR;
        ready_q <= 1'b0;
        busy_q  <= 1'b0;
        error_q <= 1'b1;
        code_q  <= 2'b11;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_ERR: if (start) begin
            state_q <= S_HDR;
            bcnt_q  <= '0;
            widx_q  <= '0;
            csum_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= 2'b00;
            hold_q  <= 1'b1;
          end
          S_HDR: if (xfer) begin
            n_q    <= shift_n;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              if (shift_n > MAX_WORDS) begin
                state_q <= S_ERR;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                code_q  <= 2'b10;
              end else if (shift_n == 32'd0) state_q <= S_CHK;
              else                           state_q <= S_DATA;
            end
          end
          S_DATA: if (xfer) begin
            word_q <= shift_w;
            csum_q <= csum_q ^ bus.byte_in;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              wr_q    <= 1'b1;
              wdata_q <= shift_w;
              addr_q  <= BASE_ADDR + {widx_q[29:0], 2'b00};
            end
          end
          S_WRITE: begin
            widx_q  <= widx_q + 32'd1;
            ready_q <= 1'b1;
            state_q <= (widx_q + 32'd1 == n_q) ? S_CHK : S_DATA;
          end
          S_CHK: if (xfer) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            if (bus.byte_in == csum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
              code_q  <= 2'b01;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.byte_ready    = ready_q;
  assign bus.imem_wr       = wr_q;
  assign bus.imem_waddress = addr_q;
  assign bus.imem_wdata    = wdata_q;
  assign cpu_hold          = hold_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign err_code          = code_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Random and directed image loads checked against a stream-parsing reference model.
module tb_imem_boot_loader;
  localparam int MAXW = 1024;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, Reset, start;
  logic       cpu_hold, busy, done, error;
  logic [1:0] err_code;
  imem_boot_loader_if bus();

  imem_boot_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .Reset(Reset), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int t_start = 0, t_done = 0;
  logic done_prev = 1'b0;
  logic [63:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.imem_wr) got.push_back({bus.imem_waddress, bus.imem_wdata});
    if (done && !done_prev) t_done = cyc;
    done_prev = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bq_t mk(input int n, input bit bad);
    bq_t q;
    logic [7:0] x, b;
    logic [31:0] nn;
    nn = n;
    x  = 8'h00;
    q  = {nn[7:0], nn[15:8], nn[23:16], nn[31:24]};
    if (n <= MAXW) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        x ^= b;
      end
      q.push_back(bad ? ~x : x);
    end
    return q;
  endfunction

  // mode 0: back-to-back, 1: valid drops every other cycle, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    int w = 0;
    if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    while (!bus.byte_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.byte_ready) begin
      chk("handshake_stall", 64'd0, 64'd1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    t_start = cyc;
    chk($sformatf("%s.st_busy", tag), 64'(busy), 64'd1);
    chk($sformatf("%s.st_hold", tag), 64'(cpu_hold), 64'd1);
    chk($sformatf("%s.st_flags", tag), {60'd0, done, error, err_code}, 64'd0);
    chk($sformatf("%s.st_ready", tag), 64'(bus.byte_ready), 64'd1);
  endtask

  task automatic run_load(input bq_t s, input int mode, input string tag);
    logic [31:0] n;
    logic [7:0]  x;
    logic [63:0] ew[$];
    int used, ecode;
    n = {s[3], s[2], s[1], s[0]};
    x = 8'h00;
    if (n > MAXW) begin
      used  = 4;
      ecode = 2;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        ew.push_back({32'(4 * i), s[4*i+7], s[4*i+6], s[4*i+5], s[4*i+4]});
        for (int j = 4; j < 8; j++) x ^= s[4*i+j];
      end
      used  = 4 + 4 * int'(n) + 1;
      ecode = (s[used-1] == x) ? 0 : 1;
    end
    got.delete();
    pulse_start(tag);
    for (int i = 0; i < used; i++) send_byte(s[i], mode);
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("%s.nwr", tag), 64'(got.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < got.size(); i++)
      chk($sformatf("%s.wr%0d", tag, i), got[i], ew[i]);
    chk($sformatf("%s.done", tag), 64'(done), 64'(ecode == 0));
    chk($sformatf("%s.error", tag), 64'(error), 64'(ecode != 0));
    chk($sformatf("%s.code", tag), 64'(err_code), 64'(ecode));
    chk($sformatf("%s.hold", tag), 64'(cpu_hold), 64'(ecode != 0));
    chk($sformatf("%s.idle", tag), {62'd0, busy, bus.byte_ready}, 64'd0);
    if (mode == 0 && ecode == 0)
      chk($sformatf("%s.cycles", tag), 64'(t_done - t_start), 64'(5 + 5 * int'(n)));
  endtask

  initial begin
    bq_t s;
    Reset = 1'b1; start = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.outs", {57'd0, cpu_hold, busy, done, error, err_code, bus.imem_wr}, 64'h40);
    chk("rst.bus", {bus.byte_ready, bus.imem_waddress, bus.imem_wdata}, 64'd0);
    Reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle.outs", {56'd0, cpu_hold, busy, done, error, err_code, bus.imem_wr, bus.byte_ready}, 64'h80);

    // The payload XORs to 0x30, so 0x17 and 0x18 both fail the checksum.
    s = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, 8'h30};
    run_load(s, 0, "plan_ok");
    if (got.size() == 2) begin
      chk("plan_ok.w0", got[0], 64'h00000000_00A00513);
      chk("plan_ok.w1", got[1], 64'h00000004_00100593);
    end else chk("plan_ok.size", 64'(got.size()), 64'd2);
    s[12] = 8'h17; run_load(s, 0, "plan_c17");
    s[12] = 8'h18; run_load(s, 0, "plan_c18");
    s = {8'h01, 8'h04, 8'h00, 8'h00};
    run_load(s, 0, "plan_big");
    s = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(s, 0, "plan_n0");
    run_load(mk(1, 1'b0), 1, "plan_toggle");
    run_load(mk(MAXW + 1, 1'b0), 0, "hdr_max1");

    for (int it = 0; it < 14; it++) begin
      int n, mode;
      bit bad;
      n    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXW + 1, 70000)) : int'($urandom_range(0, 5));
      bad  = ($urandom_range(0, 3) == 0);
      mode = int'($urandom_range(0, 2));
      run_load(mk(n, bad), mode, $sformatf("rnd%0d", it));
    end

    // Reset during the 3rd byte of word 1
    s = mk(2, 1'b0);
    got.delete();
    pulse_start("rstmid");
    for (int i = 0; i < 10; i++) send_byte(s[i], 0);
    bus.byte_in = s[10]; bus.byte_valid = 1'b1; Reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.busy", 64'(busy), 64'd0);
    chk("rstmid.hold", 64'(cpu_hold), 64'd1);
    chk("rstmid.flags", {61'd0, done, error, bus.byte_ready}, 64'd0);
    Reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    chk("rstmid.nwr", 64'(got.size()), 64'd1);
    chk("rstmid.idle", {62'd0, busy, bus.byte_ready}, 64'd0);

    // Stall inside DATA after one payload byte
    s = mk(1, 1'b0);
    pulse_start("stall");
    for (int i = 0; i < 5; i++) send_byte(s[i], 0);
`ifdef IMEM_LOADER_TIMEOUT_EN
    repeat (15) @(posedge clk);
    #1;
    chk("tmo.before", 64'(error), 64'd0);
    @(posedge clk); #1;
    chk("tmo.error", 64'(error), 64'd1);
    chk("tmo.code", 64'(err_code), 64'd3);
    chk("tmo.hold", {62'd0, cpu_hold, busy}, 64'd2);
`else
    repeat (40) @(posedge clk);
    #1;
    chk("stall.wait", {59'd0, busy, error, err_code, bus.byte_ready}, 64'h11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
